// File: rtl/regfile_dump_reader.sv
// Register file dump reader: walks a wrapping address window and
// streams {address, data} pairs over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int N_BITS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [N_BITS-1:0] rd_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_BITS-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   remaining_n;
  logic [N_BITS-1:0] data_n;
  logic [ADDR_W-1:0] addr_o_n;
  logic              valid_n;
  logic              handshake;
  logic              load;

  assign handshake = valid_o && ready_i;
  assign rd_addr_o = addr;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      data_o    <= '0;
      addr_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      data_o    <= data_n;
      addr_o    <= addr_o_n;
      valid_o   <= valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    data_n      = data_o;
    addr_o_n    = addr_o;
    valid_n     = valid_o;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          addr_n      = start_addr_i;
          // a zero count selects the whole register file
          remaining_n = (count_i == '0) ? FULL
                                        : {1'b0, count_i};
          state_n     = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          if (remaining != '0) begin
            load = 1'b1;
          end else begin
            valid_n = 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // capture sees the pre-write register value on this edge
    if (load) begin
      data_n      = rd_data_i;
      addr_o_n    = addr;
      valid_n     = 1'b1;
      addr_n      = addr + 1'b1;
      remaining_n = remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a behavioural
// register file and directed runs under varying backpressure.
module tb_regfile_dump_reader;

  localparam int N_BITS = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [ADDR_W-1:0] count_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [N_BITS-1:0] rd_data_i;
  logic              valid_o;
  logic              ready_i;
  logic [N_BITS-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;
  logic              busy_o;
  logic              done_o;

  logic [N_BITS-1:0] regs [NREG];
  logic [ADDR_W+N_BITS-1:0] sbq [$];

  int ncmp = 0;
  int nerr = 0;
  int ndone;
  int nitems;
  bit stall_pend = 0;
  logic [N_BITS-1:0] stall_d;
  logic [ADDR_W-1:0] stall_a;

  always #5 clk = ~clk;

  assign rd_data_i = regs[rd_addr_o];

  regfile_dump_reader #(
    .N_BITS(N_BITS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .count_i     (count_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .addr_o      (addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready low, 1 ready high, 2 random ready
  task automatic tick(input int mode);
    logic [ADDR_W+N_BITS-1:0] e;
    @(negedge clk);
    if (done_o) ndone++;
    if (stall_pend) begin
      chk("stall_valid", valid_o, 1);
      chk("stall_data", data_o, stall_d);
      chk("stall_addr", addr_o, stall_a);
    end
    case (mode)
      0: ready_i = 1'b0;
      1: ready_i = 1'b1;
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
    stall_pend = valid_o && !ready_i;
    stall_d = data_o;
    stall_a = addr_o;
    if (valid_o && ready_i) begin
      nitems++;
      ncmp++;
      assert (sbq.size() > 0) else begin
        nerr++;
        $error("FAIL sb_underflow observed=%0d expected=>0",
               sbq.size());
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("item", {addr_o, data_o}, e);
      end
    end
  endtask

  task automatic run(input int sa, input int cnt,
                     input int mode, input bit poke);
    int n;
    int k;
    logic [ADDR_W-1:0] a;
    n = (cnt == 0) ? NREG : cnt;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'(sa + i);
      sbq.push_back({a, regs[a]});
    end
    ndone = 0;
    nitems = 0;
    start_i = 1'b1;
    start_addr_i = ADDR_W'(sa);
    count_i = ADDR_W'(cnt);
    @(negedge clk);
    start_i = 1'b0;
    start_addr_i = ADDR_W'($urandom);
    count_i = ADDR_W'($urandom);
    chk("busy_after_start", busy_o, 1);
    chk("valid_after_start", valid_o, 0);
    k = 1;
    while (!done_o && k < 300) begin
      tick(mode);
      k++;
      if (k == 2) chk("first_valid", valid_o, 1);
      if (poke && k == 3) begin
        start_i = 1'b1;
        start_addr_i = 5'd17;
        count_i = 5'd2;
      end
      if (poke && k == 4) start_i = 1'b0;
    end
    ncmp++;
    assert (done_o) else begin
      nerr++;
      $error("FAIL done_timeout observed=%0d expected=done", k);
    end
    if (mode == 1) chk("done_cycle", k, n + 2);
    chk("item_count", nitems, n);
    chk("sb_drained", sbq.size(), 0);
    tick(mode);
    chk("busy_end", busy_o, 0);
    chk("done_width", done_o, 0);
    chk("done_pulses", ndone, 1);
    sbq.delete();
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    start_addr_i = '0;
    count_i = '0;
    ready_i = 1'b0;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + i;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr", addr_o, 0);
    reset = 1'b0;
    @(negedge clk);

    run(0, 4, 1, 0);
    run(30, 4, 1, 0);
    run(0, 0, 1, 0);

    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    run(0, 0, 2, 0);
    run(9, 20, 2, 1);
    run(27, 6, 1, 1);

    start_i = 1'b1;
    start_addr_i = 5'd5;
    count_i = 5'd8;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) tick(0);
    chk("pre_rst_valid", valid_o, 1);
    reset = 1'b1;
    stall_pend = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_rd_addr", rd_addr_o, 0);
    chk("mid_rst_addr", addr_o, 0);
    chk("mid_rst_data", data_o, 0);
    run(3, 5, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
